conv_window_buf: RTL and testbench
==================================

Name: conv_window_buf

Overview:
Parametrised successor to the conv1 3x3 binary line buffer. Accepts a raster-order pixel stream (multi-bit, multi-channel) through a valid/ready handshake and emits full KxK windows with configurable stride. Downstream backpressure is supported. Sits between the image/feature-map source and any convolution or pooling PE array in the MNIST pipeline.

Parameters:
WIDTH, 28, pixels per row (>= K)
HEIGHT, 28, rows per frame (>= K)
K, 3, kernel size, 1..7
DATA_W, 1, bits per channel sample
CH, 1, channels per pixel
STRIDE, 1, window step in x and y, 1..K

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a pixel
in_data  in  CH*DATA_W  pixel, channel c at bits [c*DATA_W +: DATA_W]
out_valid  out  1  out_window valid
out_ready  in  1  consumer accepts window
out_window  out  K*K*CH*DATA_W  window; element (r,c), channel ch at bits [((r*K+c)*CH+ch)*DATA_W +: DATA_W]; r=0 top row, c=0 left column
out_x  out  clog2(OUT_W) (min 1)  output column index
out_y  out  clog2(OUT_H) (min 1)  output row index
out_last  out  1  last window of frame

Behaviour:
- OUT_W=(WIDTH-K)/STRIDE+1, OUT_H=(HEIGHT-K)/STRIDE+1.
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (combinational). Nothing else advances state.
- Counters x (0..WIDTH-1) and y (0..HEIGHT-1) track the position of the accepted pixel; x wraps to 0 and y increments at x=WIDTH-1; at x=WIDTH-1, y=HEIGHT-1 both return to 0 (next frame starts immediately, no gap required).
- Storage: K-1 line buffers of WIDTH pixels in a rotating ring (row pointer advances on row wrap, wraps at K-2 with compare, no modulo), plus a KxK window shift register shifting left one column per accept; new right column = ring rows oldest..newest then in_data.
- Emit condition on accept of (x,y): x>=K-1, y>=K-1, and stride phase counters sx, sy both 0. sx resets to 0 at x=K-1, increments per accepted pixel, wraps at STRIDE-1; sy likewise per row from y=K-1. No divide/modulo.
- Emitted window element (r,c) = pixel(y-K+1+r, x-K+1+c). out_x=(x-K+1)/STRIDE, out_y=(y-K+1)/STRIDE (maintained as counters).
- Latency: window registered and out_valid high the cycle after the accepting edge.
- out_last = 1 with the window where out_x=OUT_W-1 and out_y=OUT_H-1; 0 otherwise.
- out_valid clears on out_ready when no new window is loaded the same cycle; accept with emit while out_valid&&out_ready reloads (back-to-back, full throughput).
- Stall: out_valid && !out_ready -> in_ready=0; out_window, out_x, out_y, out_last held stable.
- Frame boundary: windows never mix frames (first emit of a frame needs K-1 new rows in the ring).
- Reset: out_valid=0, out_window=0, out_x=0, out_y=0, out_last=0; x, y, sx, sy, row pointer=0; in_ready=1 after reset. Line buffer contents not cleared. Reset mid-frame discards partial frame; next accepted pixel is (0,0).
- in_data ignored when in_valid=0.

Test Plan:
1. Defaults, checkerboard pixel=(x^y)&1, out_ready=1, in_valid=1 -> first out_valid the cycle after accept #59 (x=2,y=2), out_window=9'h0AA, 676 windows, out_last only on 676th (out_x=25,out_y=25).
2. WIDTH=HEIGHT=6, K=3, STRIDE=2, DATA_W=8, CH=2; ch0=y*6+x, ch1=255-ch0 -> 4 windows at pixels (2,2),(4,2),(2,4),(4,4); first window centre ch0=7, ch1=248; out_x/out_y 0,1,0,1 / 0,0,1,1; out_last on 4th.
3. Defaults, out_ready low 5 cycles when first window appears -> in_ready=0, outputs frozen 5 cycles, no pixels lost, 676 windows match model.
4. Random in_valid gaps (~40%) -> window sequence identical to gapless run.
5. rst pulsed 1 cycle after pixel 300 -> out_valid=0 next cycle; fresh frame yields 676 windows all matching model of new frame only.
6. Two back-to-back frames (all-ones then all-zeros), no idle -> frame-2 first window all-zero, 1352 windows, out_last twice.

Source files
------------

// File: rtl/conv_window_buf.sv
// Raster pixel stream in, KxK sliding windows out at a configurable stride; K-1 line buffers feed a window shift register.
// Window appears the cycle after the accepting edge; while a window is held unconsumed, in_ready is low and the outputs are frozen.
module conv_window_buf #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int K      = 3,
  parameter int DATA_W = 1,
  parameter int CH     = 1,
  parameter int STRIDE = 1,
  localparam int PW    = CH * DATA_W,
  localparam int OUT_W = (WIDTH - K) / STRIDE + 1,
  localparam int OUT_H = (HEIGHT - K) / STRIDE + 1,
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K*K*PW-1:0]     out_window,
  output logic [OXW-1:0]        out_x,
  output logic [OYW-1:0]        out_y,
  output logic                  out_last
);

  localparam int SW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int RPW    = (K > 2) ? $clog2(K - 1) : 1;
  localparam int LB     = (K > 1) ? K - 1 : 1;
  localparam int RP_MAX = (K > 1) ? K - 2 : 0;

  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [SW-1:0]      r_sx, r_sy;
  logic [OXW-1:0]     r_cx;
  logic [OYW-1:0]     r_cy;
  logic [RPW-1:0]     r_rp;
  logic [PW-1:0]      r_lb [LB][WIDTH];
  logic [K*K*PW-1:0]  r_win;

  logic               r_out_valid;
  logic [K*K*PW-1:0]  r_out_window;
  logic [OXW-1:0]     r_out_x;
  logic [OYW-1:0]     r_out_y;
  logic               r_out_last;

  logic               w_acc, w_emit, w_x_end, w_y_end;
  logic [SW-1:0]      w_sx_cur, w_sy_cur;
  logic [OXW-1:0]     w_cx_cur;
  logic [OYW-1:0]     w_cy_cur;
  logic [PW-1:0]      w_col [K];
  logic [K*K*PW-1:0]  w_win_nxt;

  // Ring slot holding row (y-K+1+off) of the current frame; base is the oldest row.
  function automatic logic [RPW-1:0] ring_slot(input logic [RPW-1:0] base, input int off);
    logic [RPW:0] s;
    s = {1'b0, base} + (RPW+1)'(off);
    if (s >= (RPW+1)'(K - 1)) s = s - (RPW+1)'(K - 1);
    return s[RPW-1:0];
  endfunction

  assign in_ready = !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_x_end  = (r_x == XW'(WIDTH - 1));
  assign w_y_end  = (r_y == YW'(HEIGHT - 1));

  // Phase and output-index counters restart at the first column/row that can hold a full window.
  assign w_sx_cur = (r_x == XW'(K - 1)) ? '0 : r_sx;
  assign w_sy_cur = (r_y == YW'(K - 1)) ? '0 : r_sy;
  assign w_cx_cur = (r_x == XW'(K - 1)) ? '0 : r_cx;
  assign w_cy_cur = (r_y == YW'(K - 1)) ? '0 : r_cy;

  assign w_emit = w_acc && (r_x >= XW'(K - 1)) && (r_y >= YW'(K - 1))
                  && (w_sx_cur == '0) && (w_sy_cur == '0);

  always_comb begin
    for (int r = 0; r < K; r++) w_col[r] = in_data;
    for (int r = 0; r < K - 1; r++) w_col[r] = r_lb[ring_slot(r_rp, r)][r_x];
  end

  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (c < K - 1) w_win_nxt[(r*K+c)*PW +: PW] = r_win[(r*K+c+1)*PW +: PW];
        else           w_win_nxt[(r*K+c)*PW +: PW] = w_col[r];
      end
    end
  end

  generate
    if (K > 1) begin : g_lb
      always_ff @(posedge clk) begin
        if (w_acc) r_lb[r_rp][r_x] <= in_data;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_acc) r_win <= w_win_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_sx <= '0;
      r_sy <= '0;
      r_cx <= '0;
      r_cy <= '0;
      r_rp <= '0;
    end else if (w_acc) begin
      r_x  <= w_x_end ? '0 : r_x + 1'b1;
      r_sx <= (w_sx_cur == SW'(STRIDE - 1)) ? '0 : w_sx_cur + 1'b1;
      if (w_emit) r_cx <= w_cx_cur + 1'b1;
      if (w_x_end) begin
        r_y  <= w_y_end ? '0 : r_y + 1'b1;
        r_rp <= (r_rp == RPW'(RP_MAX)) ? '0 : r_rp + 1'b1;
        r_sy <= (w_sy_cur == SW'(STRIDE - 1)) ? '0 : w_sy_cur + 1'b1;
        if ((r_y >= YW'(K - 1)) && (w_sy_cur == '0)) r_cy <= w_cy_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_last   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid  <= 1'b1;
      r_out_window <= w_win_nxt;
      r_out_x      <= w_cx_cur;
      r_out_y      <= w_cy_cur;
      r_out_last   <= (w_cx_cur == OXW'(OUT_W - 1)) && (w_cy_cur == OYW'(OUT_H - 1));
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_window = r_out_window;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_conv_window_buf.sv
// Scoreboard bench: drivers push expected windows from a frame image model; monitors pop on each output handshake.
module tb_conv_window_buf;
  localparam int W = 28;
  localparam int H = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [0:0]  in_data;
  logic [8:0]  out_window;
  logic [4:0]  out_x, out_y;

  conv_window_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  logic         rst2, in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [15:0]  in_data2;
  logic [143:0] out_window2;
  logic [0:0]   out_x2, out_y2;

  conv_window_buf #(.WIDTH(6), .HEIGHT(6), .K(3), .DATA_W(8), .CH(2), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_window(out_window2),
    .out_x(out_x2), .out_y(out_y2), .out_last(out_last2)
  );

  typedef struct { logic [8:0]   win; int ox; int oy; bit last; } exp1_t;
  typedef struct { logic [143:0] win; int ox; int oy; bit last; } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];
  bit    img[H][W];
  int    n_chk = 0, n_err = 0;
  int    mx = 0, my = 0, n_acc = 0, n_win = 0, n_last = 0, n_win2 = 0, n_last2 = 0;
  int    chk_zero_at = -1;
  bit    chk_first = 0, done2 = 0;

  task automatic check(input bit ok, input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pix(input int pat, input int x, input int y);
    case (pat)
      0: return ((x ^ y) & 1) != 0;
      1: return ((x + 2 * y) % 3) == 0;
      2: return (((x * y) >> 1) & 1) != 0;
      3: return 1'b1;
      4: return 1'b0;
      default: return ((x * 7 + y * 3) % 5) < 2;
    endcase
  endfunction

  function automatic logic [8:0] win1(input int x, input int y);
    logic [8:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r*3+c] = img[y-2+r][x-2+c];
    return w;
  endfunction

  function automatic logic [143:0] win2(input int x, input int y);
    logic [143:0] w;
    int v;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        v = (y - 2 + r) * 6 + (x - 2 + c);
        w[((r*3+c)*2)*8 +: 8]   = 8'(v);
        w[((r*3+c)*2+1)*8 +: 8] = 8'(255 - v);
      end
    return w;
  endfunction

  task automatic send_pixel(input bit d, input int gap_pct);
    int tries;
    bit acc;
    exp1_t e;
    tries = 0;
    acc = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(negedge clk); in_valid = 1'b0; in_data = 1'($urandom);
    end
    while (!acc && tries < 2000) begin
      @(negedge clk); in_valid = 1'b1; in_data = d;
      #1 acc = in_ready;
      @(posedge clk);
      tries++;
    end
    if (!acc) begin
      check(1'b0, "accept_timeout", 160'(tries), 160'(0));
      return;
    end
    n_acc++;
    img[my][mx] = d;
    if (mx >= 2 && my >= 2) begin
      e.win = win1(mx, my); e.ox = mx - 2; e.oy = my - 2; e.last = (mx == W-1 && my == H-1);
      q1.push_back(e);
    end
    if (mx == W-1) begin mx = 0; my = (my == H-1) ? 0 : my + 1; end
    else mx++;
  endtask

  task automatic send_frame(input int pat, input int gap_pct, input int stop_after);
    for (int i = 0; i < W*H && i < stop_after; i++) send_pixel(pix(pat, i % W, i / W), gap_pct);
  endtask

  task automatic idle_drain(input string name);
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 500 && q1.size() != 0; i++) @(negedge clk);
    check(q1.size() == 0, name, 160'(q1.size()), 160'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic stall_proc();
    bit found;
    logic [19:0] snap;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin @(posedge clk); #2 found = out_valid; end
    check(found, "stall_window_seen", 160'(found), 160'(1));
    if (found) begin
      out_ready = 1'b0;
      snap = {out_last, out_y, out_x, out_window};
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #2;
        check(in_ready === 1'b0 && out_valid === 1'b1, "stall_handshake", 160'({in_ready, out_valid}), 160'(2'b01));
        check({out_last, out_y, out_x, out_window} === snap, "stall_hold", 160'({out_last, out_y, out_x, out_window}), 160'(snap));
      end
      @(posedge clk); #2 out_ready = 1'b1;
    end
  endtask

  initial begin : mon1
    exp1_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (chk_first) begin
          chk_first = 0;
          check(n_acc == 59, "first_latency", 160'(n_acc), 160'(59));
          check(out_window === 9'h0AA, "first_window", 160'(out_window), 160'(9'h0AA));
        end
        if (out_ready) begin
          if (n_win == chk_zero_at) check(out_window === 9'd0, "frame2_first_zero", 160'(out_window), 160'(0));
          if (q1.size() == 0) check(1'b0, "unexpected_window", 160'(out_window), 160'(0));
          else begin
            e = q1.pop_front();
            check(out_window === e.win && out_x === 5'(e.ox) && out_y === 5'(e.oy) && out_last === e.last,
                  "window", 160'({out_last, out_y, out_x, out_window}), 160'({e.last, 5'(e.oy), 5'(e.ox), e.win}));
          end
          n_win++;
          if (out_last) n_last++;
        end
      end
    end
  end

  initial begin : mon2
    exp2_t e;
    forever begin
      @(negedge clk);
      if (!rst2 && out_valid2 && out_ready2) begin
        if (n_win2 == 0)
          check(out_window2[71:64] === 8'd7 && out_window2[79:72] === 8'd248, "t2_centre",
                160'(out_window2[79:64]), 160'(16'hF807));
        if (q2.size() == 0) check(1'b0, "t2_unexpected_window", 160'(out_window2), 160'(0));
        else begin
          e = q2.pop_front();
          check(out_window2 === e.win && out_x2 === 1'(e.ox) && out_y2 === 1'(e.oy) && out_last2 === e.last,
                "t2_window", 160'({out_last2, out_y2, out_x2, out_window2}), 160'({e.last, 1'(e.oy), 1'(e.ox), e.win}));
        end
        n_win2++;
        if (out_last2) n_last2++;
      end
    end
  end

  initial begin : drv2
    exp2_t e;
    rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst2 = 1'b0;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) begin
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = {8'(255 - (y*6 + x)), 8'(y*6 + x)};
        #1 check(in_ready2 === 1'b1, "t2_in_ready", 160'(in_ready2), 160'(1));
        if (x >= 2 && y >= 2 && (x % 2) == 0 && (y % 2) == 0) begin
          e.win = win2(x, y); e.ox = (x - 2) / 2; e.oy = (y - 2) / 2; e.last = (x == 4 && y == 4);
          q2.push_back(e);
        end
        @(posedge clk);
      end
    @(negedge clk); in_valid2 = 1'b0;
    for (int i = 0; i < 50 && q2.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(n_win2 == 4 && q2.size() == 0, "t2_count", 160'(n_win2), 160'(4));
    check(n_last2 == 1, "t2_last_count", 160'(n_last2), 160'(1));
    done2 = 1;
  end

  initial begin : main
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(out_valid === 1'b0 && in_ready === 1'b1, "reset_handshake", 160'({out_valid, in_ready}), 160'(2'b01));
    check({out_last, out_y, out_x, out_window} === 20'd0, "reset_outputs", 160'({out_last, out_y, out_x, out_window}), 160'(0));
    rst = 1'b0;

    // checkerboard, gapless, first-window timing
    n_acc = 0; n_win = 0; n_last = 0; chk_first = 1;
    send_frame(0, 0, W*H);
    idle_drain("t1_drain");
    check(n_win == 676, "t1_count", 160'(n_win), 160'(676));
    check(n_last == 1, "t1_last_count", 160'(n_last), 160'(1));
    check(chk_first == 0, "t1_first_seen", 160'(chk_first), 160'(0));

    // consumer stall on the first window
    n_win = 0; n_last = 0;
    fork
      send_frame(1, 0, W*H);
      stall_proc();
    join
    idle_drain("t3_drain");
    check(n_win == 676, "t3_count", 160'(n_win), 160'(676));

    // random input gaps
    n_win = 0; n_last = 0;
    send_frame(2, 40, W*H);
    idle_drain("t4_drain");
    check(n_win == 676 && n_last == 1, "t4_count", 160'({n_win, n_last}), 160'({32'd676, 32'd1}));

    // reset one cycle after pixel 300, then a fresh frame
    send_frame(5, 0, 300);
    @(negedge clk); in_valid = 1'b0;
    #2 rst = 1'b1;
    q1.delete(); mx = 0; my = 0;
    @(posedge clk);
    @(negedge clk);
    check(out_valid === 1'b0 && in_ready === 1'b1, "t5_reset_clears", 160'({out_valid, in_ready}), 160'(2'b01));
    rst = 1'b0;
    n_win = 0; n_last = 0;
    send_frame(2, 0, W*H);
    idle_drain("t5_drain");
    check(n_win == 676 && n_last == 1, "t5_count", 160'({n_win, n_last}), 160'({32'd676, 32'd1}));

    // two back-to-back frames, no idle between them
    n_win = 0; n_last = 0; chk_zero_at = 676;
    send_frame(3, 0, W*H);
    send_frame(4, 0, W*H);
    idle_drain("t6_drain");
    chk_zero_at = -1;
    check(n_win == 1352, "t6_count", 160'(n_win), 160'(1352));
    check(n_last == 2, "t6_last_count", 160'(n_last), 160'(2));

    for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
    check(done2, "t2_done", 160'(done2), 160'(1));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
